pipe_stage_skid: RTL and testbench

- Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque DATA_W payload using ls_valid/ts_ready/ts_valid/ns_ready handshakes, with global stall and flush inputs.
- A 2-entry skid buffer gives full throughput while ts_ready stays a pure flop output. No combinational path exists from ns_ready to ts_ready.
- Stage-specific structs are packed into and unpacked from data by the instantiating stage.

---
 rtl/pipe_stage_skid.sv | 98 +++++++++
 tb/tb_pipe_stage_skid.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer.
// ts_ready is decoded purely from the state flop, so ns_ready never reaches it combinationally.
module pipe_stage_skid #(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid,
    input  logic [DATA_W-1:0] ls_data,
    output logic              ts_ready,
    output logic              ts_valid,
    output logic [DATA_W-1:0] ts_data,
    input  logic              ns_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    // state | meaning
    // EMPTY | no entries held, ready to accept
    // ONE   | main entry valid, ready to accept
    // FULL  | main and skid valid, skid is younger, not ready
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    assign ts_ready  = (state_q != ST_FULL);
    assign ts_valid  = (state_q != ST_EMPTY);
    assign ts_data   = main_q;
    assign occupancy = state_q;

    assign in_fire  = ls_valid & ts_ready & ~stall & ~flush;
    assign out_fire = ts_valid & ns_ready & ~stall & ~flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = ls_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = ls_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = ls_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // skid is older than anything upstream, so it moves up into main
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifndef SYNTHESIS
    // upstream must hold its payload while it is being refused
    ls_data_hold: assert property (@(posedge clk) disable iff (rst)
        (ls_valid && !ts_ready && !flush) |=> (!ls_valid || $stable(ls_data)))
        else $error("ls_data changed while held off by ts_ready=0");
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush, stall, reset mid-FULL.
module tb_pipe_stage_skid;

    localparam int          DATA_W = 32;
    localparam logic [31:0] RDATA  = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_data;
    logic              ts_ready;
    logic              ts_valid;
    logic [DATA_W-1:0] ts_data;
    logic              ns_ready;
    logic              stall;
    logic              flush;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .RESET_DATA(RDATA)) dut (
        .clk(clk), .rst(rst),
        .ls_valid(ls_valid), .ls_data(ls_data), .ts_ready(ts_ready),
        .ts_valid(ts_valid), .ts_data(ts_data), .ns_ready(ns_ready),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ls_valid = 1'b1; ls_data = 32'hAAAA_AAAA;
        ns_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        step();
        rst = 1'b0; ls_valid = 1'b0;
        checks++;
        if (ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ts_valid); end
        checks++;
        if (ts_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ts_ready); end
        checks++;
        if (ts_data !== RDATA) begin errors++; $display("FAIL reset_data got %h exp %h", ts_data, RDATA); end
        checks++;
        if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_streaming();
        ns_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ls_valid = 1'b1; ls_data = i;
            step();
            checks++;
            if (ts_data !== 32'(i) || ts_valid !== 1'b1)
                begin errors++; $display("FAIL stream_data got %h/%b exp %h/1", ts_data, ts_valid, i); end
            checks++;
            if (ts_ready !== 1'b1 || occupancy !== 2'd1)
                begin errors++; $display("FAIL stream_ready_occ got %b/%0d exp 1/1", ts_ready, occupancy); end
        end
        ls_valid = 1'b0;
        step();
        checks++;
        if (ts_valid !== 1'b0 || occupancy !== 2'd0)
            begin errors++; $display("FAIL stream_drain got %b/%0d exp 0/0", ts_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        ns_ready = 1'b0; ls_valid = 1'b1; ls_data = 32'h10;
        step();
        checks++;
        if (occupancy !== 2'd1 || ts_ready !== 1'b1 || ts_data !== 32'h10)
            begin errors++; $display("FAIL bp_first got occ=%0d rdy=%b d=%h exp 1/1/10", occupancy, ts_ready, ts_data); end
        ls_data = 32'h11;
        step();
        checks++;
        if (occupancy !== 2'd2 || ts_ready !== 1'b0 || ts_data !== 32'h10)
            begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b d=%h exp 2/0/10", occupancy, ts_ready, ts_data); end
        ls_data = 32'h12;
        step();
        checks++;
        if (occupancy !== 2'd2 || ts_ready !== 1'b0 || ts_data !== 32'h10)
            begin errors++; $display("FAIL bp_holdoff got occ=%0d rdy=%b d=%h exp 2/0/10", occupancy, ts_ready, ts_data); end
        ns_ready = 1'b1;
        step();
        checks++;
        if (occupancy !== 2'd1 || ts_ready !== 1'b1 || ts_data !== 32'h11)
            begin errors++; $display("FAIL bp_drain1 got occ=%0d rdy=%b d=%h exp 1/1/11", occupancy, ts_ready, ts_data); end
        step();
        checks++;
        if (occupancy !== 2'd1 || ts_valid !== 1'b1 || ts_data !== 32'h12)
            begin errors++; $display("FAIL bp_drain2 got occ=%0d vld=%b d=%h exp 1/1/12", occupancy, ts_valid, ts_data); end
        ls_valid = 1'b0;
        step();
        checks++;
        if (occupancy !== 2'd0 || ts_valid !== 1'b0)
            begin errors++; $display("FAIL bp_empty got occ=%0d vld=%b exp 0/0", occupancy, ts_valid); end
    endtask

    task automatic test_flush_full();
        ns_ready = 1'b0; ls_valid = 1'b1; ls_data = 32'h20;
        step();
        ls_data = 32'h21;
        step();
        checks++;
        if (occupancy !== 2'd2)
            begin errors++; $display("FAIL flush_setup got occ=%0d exp 2", occupancy); end
        ls_data = 32'h22; flush = 1'b1; ns_ready = 1'b1;
        step();
        checks++;
        if (ts_valid !== 1'b0 || occupancy !== 2'd0 || ts_ready !== 1'b1)
            begin errors++; $display("FAIL flush_empty got vld=%b occ=%0d rdy=%b exp 0/0/1", ts_valid, occupancy, ts_ready); end
        flush = 1'b0; ls_valid = 1'b0;
        step();
        checks++;
        if (ts_valid !== 1'b0 || ts_data !== 32'h20)
            begin errors++; $display("FAIL flush_discard got vld=%b d=%h exp 0/20", ts_valid, ts_data); end
    endtask

    task automatic test_stall();
        ns_ready = 1'b0; ls_valid = 1'b1; ls_data = 32'h30;
        step();
        ls_data = 32'h31; ns_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ts_data !== 32'h30 || ts_valid !== 1'b1 || occupancy !== 2'd1)
                begin errors++; $display("FAIL stall_frozen got d=%h vld=%b occ=%0d exp 30/1/1", ts_data, ts_valid, occupancy); end
        end
        stall = 1'b0;
        step();
        checks++;
        if (ts_data !== 32'h31 || occupancy !== 2'd1)
            begin errors++; $display("FAIL stall_release got d=%h occ=%0d exp 31/1", ts_data, occupancy); end
        ls_valid = 1'b0;
        step();
        checks++;
        if (occupancy !== 2'd0)
            begin errors++; $display("FAIL stall_drain got occ=%0d exp 0", occupancy); end
    endtask

    task automatic test_flush_stall_reset();
        ns_ready = 1'b0; ls_valid = 1'b1; ls_data = 32'h40;
        step();
        ls_data = 32'h41;
        step();
        ls_valid = 1'b0; flush = 1'b1; stall = 1'b1;
        step();
        checks++;
        if (occupancy !== 2'd0 || ts_valid !== 1'b0 || ts_ready !== 1'b1)
            begin errors++; $display("FAIL flushstall got occ=%0d vld=%b rdy=%b exp 0/0/1", occupancy, ts_valid, ts_ready); end
        flush = 1'b0; stall = 1'b0; ls_valid = 1'b1; ls_data = 32'h50;
        step();
        ls_data = 32'h51;
        step();
        checks++;
        if (occupancy !== 2'd2 || ts_data !== 32'h50)
            begin errors++; $display("FAIL rstfull_setup got occ=%0d d=%h exp 2/50", occupancy, ts_data); end
        rst = 1'b1;
        step();
        rst = 1'b0; ls_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || ts_valid !== 1'b0 || ts_ready !== 1'b1 || ts_data !== RDATA)
            begin errors++; $display("FAIL rstfull got occ=%0d vld=%b rdy=%b d=%h exp 0/0/1/%h", occupancy, ts_valid, ts_ready, ts_data, RDATA); end
    endtask

    initial begin
        rst = 1'b1; ls_valid = 1'b0; ls_data = '0;
        ns_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_stall();
        test_flush_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
